// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues sequential word fetches under a credit limit
// and buffers in-order responses in a small FIFO in front of the decoder.
module fetch_unit #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           FIFO_DEPTH = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_en,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  inst_valid,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [DATA_WIDTH-1:0] inst_pc,
  input  logic                  inst_ready
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);
  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

  typedef enum logic {IDLE, FETCH} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATA_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]         outstanding_q, outstanding_d;
  logic [CW-1:0]         discard_q, discard_d;
  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] data_mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] pc_mem_q   [FIFO_DEPTH];

  logic [CW:0] credit_used;
  logic        accept, retire, drop, push, pop;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fetch_en)  state_d = FETCH;
      FETCH:   if (!fetch_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Credits already spoken for: buffered entries plus in-flight requests that will be kept.
  assign credit_used = {1'b0, count_q} + {1'b0, outstanding_q} - {1'b0, discard_q};
  assign imem_req    = (state_q == FETCH) && !redirect_valid && (credit_used < DEPTH_C);
  assign imem_addr   = fetch_pc_q & ALIGN_MASK;
  assign accept      = imem_req && imem_ready;
  assign retire      = imem_rvalid && (outstanding_q != '0);
  assign drop        = retire && (discard_q != '0);
  assign push        = retire && !drop && !redirect_valid;
  assign inst_valid  = (count_q != '0);
  assign pop         = inst_valid && inst_ready && !redirect_valid;
  assign inst        = data_mem_q[rd_ptr_q];
  assign inst_pc     = pc_mem_q[rd_ptr_q];

  // Requests after a redirect are strictly sequential and responses come back in order,
  // so the PC of every kept response is a running counter from the last redirect target.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q + CW'(accept) - CW'(retire);
    discard_d     = discard_q - CW'(drop);
    count_d       = count_q + CW'(push) - CW'(pop);
    wr_ptr_d      = wr_ptr_q + PW'(push);
    rd_ptr_d      = rd_ptr_q + PW'(pop);
    if (accept) fetch_pc_d = fetch_pc_q + DATA_WIDTH'(4);
    if (push)   rsp_pc_d   = rsp_pc_q + DATA_WIDTH'(4);
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ALIGN_MASK;
      rsp_pc_d   = redirect_pc & ALIGN_MASK;
      discard_d  = outstanding_d;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC & ALIGN_MASK;
      rsp_pc_q      <= RESET_PC & ALIGN_MASK;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else if (push) begin
      data_mem_q[wr_ptr_q] <= imem_rdata;
      pc_mem_q[wr_ptr_q]   <= rsp_pc_q;
    end
  end

  // The credit rule should make this unreachable.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && (count_q == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model with tagged requests and an
// instruction scoreboard filled on responses and drained on decoder pops.
module tb_fetch_unit;

  localparam int          DW       = 32;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] addr;
    int          gen;
    int          due;
  } memEntry_t;

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
  } instEntry_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fetch_en, redirect_valid, imem_ready, imem_rvalid, inst_ready;
  logic [DW-1:0] redirect_pc, imem_rdata;
  logic          imem_req, inst_valid;
  logic [DW-1:0] imem_addr, inst, inst_pc;

  memEntry_t   memQ[$];
  instEntry_t  sb[$];
  int          checkCnt = 0;
  int          passCnt = 0;
  int          gen = 0;
  int          edgeNum = 0;
  int          firstValidEdge = -1;
  int          acceptCnt = 0;
  int          popCnt = 0;
  logic [31:0] modelPc = RESET_PC;
  logic [31:0] firstAcceptAddr = '0;
  logic [31:0] firstPopPc = '0;
  logic        stateFetch = 1'b0;

  fetch_unit #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCnt++;
    if (observed === expected) passCnt++;
    else $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  function automatic int liveInflight();
    int n = 0;
    foreach (memQ[i]) if (memQ[i].gen == gen) n++;
    return n;
  endfunction

  // One cycle, entered and left at a falling edge. rmode: 0 respond when due, 1 hold, 2 random.
  task automatic applyStimulus(input logic en, input logic rdy, input int rmode,
                               input logic iready, input logic redir, input logic [31:0] rpc);
    logic       doResp;
    logic       expReq;
    memEntry_t  head;
    instEntry_t exp;
    fetch_en       = en;
    imem_ready     = rdy;
    inst_ready     = iready;
    redirect_valid = redir;
    redirect_pc    = rpc;
    doResp = 1'b0;
    if (memQ.size() != 0 && memQ[0].due <= edgeNum + 1) begin
      case (rmode)
        0:       doResp = 1'b1;
        1:       doResp = 1'b0;
        default: doResp = 1'($urandom_range(0, 1));
      endcase
    end
    imem_rvalid = doResp;
    imem_rdata  = doResp ? memQ[0].addr + 32'd100 : $urandom;
    #1;
    expReq = stateFetch && !redir && (sb.size() + liveInflight() < DEPTH);
    checkOutput("imem_req", imem_req, expReq);
    checkOutput("inst_valid", inst_valid, sb.size() != 0);
    if (inst_valid && firstValidEdge < 0) firstValidEdge = edgeNum;
    if (inst_valid && iready && sb.size() != 0) begin
      exp = sb.pop_front();
      checkOutput("inst", inst, exp.data);
      checkOutput("inst_pc", inst_pc, exp.pc);
      if (popCnt == 0) firstPopPc = inst_pc;
      popCnt++;
    end
    if (doResp) begin
      head = memQ.pop_front();
      if (!redir && head.gen == gen) sb.push_back('{data: head.addr + 32'd100, pc: head.addr});
    end
    if (imem_req && rdy) begin
      checkOutput("imem_addr", imem_addr, modelPc);
      if (acceptCnt == 0) firstAcceptAddr = imem_addr;
      memQ.push_back('{addr: modelPc, gen: gen, due: edgeNum + 2});
      modelPc = modelPc + 32'd4;
      acceptCnt++;
    end
    if (redir) begin
      sb.delete();
      gen++;
      modelPc = rpc & 32'hFFFF_FFFC;
    end
    stateFetch = en;
    @(posedge clk);
    edgeNum++;
    @(negedge clk);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_imem_req", imem_req, 1'b0);
    checkOutput("rst_inst_valid", inst_valid, 1'b0);
    checkOutput("rst_inst", inst, 32'h0);
    checkOutput("rst_inst_pc", inst_pc, 32'h0);
    checkOutput("rst_imem_addr", imem_addr, RESET_PC);
    memQ.delete();
    sb.delete();
    gen++;
    modelPc        = RESET_PC;
    stateFetch     = 1'b0;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    imem_rvalid    = 1'b0;
    inst_ready     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n          = 1'b1;
    edgeNum        = 0;
    firstValidEdge = -1;
  endtask

  task automatic drainAll();
    int guard = 0;
    while ((memQ.size() != 0 || sb.size() != 0 || stateFetch) && guard < 200) begin
      applyStimulus(1'b0, 1'b1, 0, 1'b1, 1'b0, 32'h0);
      guard++;
    end
    checkOutput("drain_bound", guard < 200, 1'b1);
  endtask

  task automatic holdTwo();
    drainAll();
    acceptCnt = 0;
    repeat (4) applyStimulus(1'b1, 1'b1, 1, 1'b0, 1'b0, 32'h0);
    checkOutput("held_reqs", acceptCnt, 2);
  endtask

  task automatic runUntilPop(input logic en);
    int guard = 0;
    popCnt = 0;
    acceptCnt = 0;
    while (popCnt == 0 && guard < 50) begin
      applyStimulus(en, 1'b1, 0, 1'b1, 1'b0, 32'h0);
      guard++;
    end
    checkOutput("pop_bound", guard < 50, 1'b1);
  endtask

  initial begin
    logic randEn;
    rst_n          = 1'b1;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_ready     = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    inst_ready     = 1'b0;
    @(negedge clk);
    doReset();

    // Streaming from reset: first instruction three cycles after fetch_en.
    repeat (20) applyStimulus(1'b1, 1'b1, 0, 1'b1, 1'b0, 32'h0);
    checkOutput("first_inst_cycle", firstValidEdge, 3);

    // Decoder stall fills the buffer with exactly two requests.
    drainAll();
    acceptCnt = 0;
    repeat (8) applyStimulus(1'b1, 1'b1, 0, 1'b0, 1'b0, 32'h0);
    checkOutput("stall_reqs", acceptCnt, 2);
    repeat (12) applyStimulus(1'b1, 1'b1, 0, 1'b1, 1'b0, 32'h0);

    // fetch_en dropped with a request in flight.
    drainAll();
    repeat (2) applyStimulus(1'b1, 1'b1, 1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1, 1'b1, 1'b0, 32'h0);
    acceptCnt = 0;
    repeat (4) applyStimulus(1'b0, 1'b1, 0, 1'b1, 1'b0, 32'h0);
    checkOutput("idle_reqs", acceptCnt, 0);
    repeat (10) applyStimulus(1'b1, 1'b1, 0, 1'b1, 1'b0, 32'h0);

    // Redirect with two responses outstanding.
    holdTwo();
    applyStimulus(1'b1, 1'b1, 1, 1'b0, 1'b1, 32'h0000_0103);
    runUntilPop(1'b1);
    checkOutput("redir_addr", firstAcceptAddr, 32'h0000_0100);
    checkOutput("redir_first_pc", firstPopPc, 32'h0000_0100);

    // Redirect in the same cycle as a pop and a response.
    drainAll();
    repeat (3) applyStimulus(1'b1, 1'b1, 1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1, 1'b0, 1'b0, 32'h0);
    popCnt = 0;
    applyStimulus(1'b0, 1'b1, 0, 1'b1, 1'b1, 32'h0000_0200);
    checkOutput("redir_pop_once", popCnt, 1);
    runUntilPop(1'b1);
    checkOutput("redir2_addr", firstAcceptAddr, 32'h0000_0200);
    checkOutput("redir2_first_pc", firstPopPc, 32'h0000_0200);

    // Back-to-back redirects: the last target wins.
    holdTwo();
    applyStimulus(1'b1, 1'b1, 1, 1'b0, 1'b1, 32'h0000_0300);
    applyStimulus(1'b1, 1'b1, 0, 1'b0, 1'b1, 32'h0000_0406);
    runUntilPop(1'b1);
    checkOutput("b2b_addr", firstAcceptAddr, 32'h0000_0404);
    checkOutput("b2b_first_pc", firstPopPc, 32'h0000_0404);

    // Random memory latency, decoder back-pressure, enables and redirects.
    randEn = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) randEn = ~randEn;
      applyStimulus(randEn, 1'($urandom_range(0, 1)), 2, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 31) == 0), $urandom);
    end
    drainAll();

    // Reset in the middle of traffic.
    repeat (4) applyStimulus(1'b1, 1'b1, 2, 1'b0, 1'b0, 32'h0);
    doReset();
    repeat (20) applyStimulus(1'b1, 1'($urandom_range(0, 1)), 2, 1'($urandom_range(0, 1)), 1'b0, 32'h0);
    drainAll();

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
